// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Operates on operand magnitudes over WIDTH iterations, then applies the sign when it enters DONE.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // state  | meaning
    // S_IDLE | no operation in flight
    // S_MUL  | shift-add multiply iterations on magnitudes
    // S_DIV  | restoring divide iterations on magnitudes
    // S_DONE | result valid, ready pulse for one cycle
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   opnd;
    logic               neg;
    logic               div_zero;

    logic               start;
    logic               iter_done;
    logic               finish;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_nxt;

    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   div_res;
    logic               div_exc;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign iter_done = (cnt == '0);
    assign busy      = (state == S_MUL) || (state == S_DIV);
    assign finish    = busy && iter_done && !start;
    assign data_resultRDY = (state == S_DONE);

    // Magnitude of the most-negative value wraps to itself, which reads correctly as unsigned.
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ctrl_MULT ? S_MUL : S_DIV;
        end else begin
            case (state)
                S_MUL, S_DIV: if (iter_done) state_nxt = S_DONE;
                S_DONE:       state_nxt = S_IDLE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    // One iteration step: multiply keeps {acc, multiplier}, divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (state == S_MUL) begin
            step_nxt = {mul_sum, work[WIDTH-1:1]};
        end else if (div_ge) begin
            step_nxt = {div_diff, work[WIDTH-2:0], 1'b1};
        end else begin
            step_nxt = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_signed = neg ? -work : work;
        prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
        mul_exc     = !((&prod_top) || !(|prod_top));
        quot_signed = neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        div_res     = div_zero ? '0 : quot_signed;
        // Only most-negative / -1 produces a positive quotient magnitude of 2^(WIDTH-1).
        div_exc     = div_zero || (!neg && work[WIDTH-1]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            work           <= '0;
            opnd           <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            work     <= {{WIDTH{1'b0}}, (ctrl_MULT ? abs_b : abs_a)};
            opnd     <= ctrl_MULT ? abs_a : abs_b;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
        end else if (busy && !iter_done) begin
            cnt  <= cnt - CW'(1);
            work <= step_nxt;
        end else if (finish) begin
            data_result    <= (state == S_MUL) ? prod_signed[WIDTH-1:0] : div_res;
            data_exception <= (state == S_MUL) ? mul_exc : div_exc;
        end
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit for the execute stage of the 5-stage pipeline.
- Receives operands and a one-cycle start pulse when a mul/div instruction reaches DX.
- Returns a result, exception flag and one-cycle ready pulse.
- The pipeline stalls on busy and, when ready pulses, forwards the result into the XM latch. On exception, rstatus is written.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clock  input  1  master clock, rising-edge active
reset  input  1  asynchronous, active-low reset
data_operandA  input  WIDTH  multiplicand / dividend, sampled on accepting edge
data_operandB  input  WIDTH  multiplier / divisor, sampled on accepting edge
ctrl_MULT  input  1  start multiply; single-cycle pulse
ctrl_DIV  input  1  start divide; single-cycle pulse
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY
data_resultRDY  output  1  result valid; high exactly one cycle
busy  output  1  operation in flight; pipeline stall request

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE, counter to 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation aborts the operation; no data_resultRDY is produced.
- States:
  - IDLE to MUL on ctrl_MULT; IDLE to DIV on ctrl_DIV.
  - MUL/DIV to DONE after WIDTH iteration edges.
  - DONE to IDLE on the next edge, unless a new start arrives.
- Start acceptance:
  - A start is accepted on any rising edge in any state.
  - Operands and op type are latched on the accepting edge.
  - A start during MUL/DIV/DONE aborts the current op and restarts; the aborted op never raises ready.
  - If ctrl_MULT and ctrl_DIV are asserted together, multiply wins.
- Latency:
  - Accepting edge is E0.
  - Iterations run on E1..E32; DONE is entered at E33.
  - data_resultRDY=1 for the single cycle following E33.
  - Latency is fixed for every operand value, including exception cases.
- busy: 1 from E0 through E32 (inclusive); 0 in DONE and IDLE.
- Output hold:
  - data_result and data_exception update only at entry to DONE.
  - They hold until the next DONE entry or reset; they are stable outside the ready cycle.
- Multiply:
  - Signed two's-complement; shift-add or radix-2 Booth over a 2*WIDTH product register.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2*WIDTH-1:WIDTH-1] is not all-equal (product does not fit in WIDTH signed).
- Divide:
  - Restoring or non-restoring on magnitudes; sign is fixed up at DONE.
  - Quotient truncates toward zero; remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1.
  - Dividend = most-negative and divisor = -1: data_result=32'h80000000, data_exception=1.
- Operand inputs may change freely after E0 without affecting the result.
- No internal handling of pipeline flush. A squash is performed by the pipeline driving reset low or issuing a new start.

Test Plan:
- MULT 7 x -3 (A=7, B=32'hFFFFFFFD) -> data_resultRDY high exactly in the cycle after E33; data_result=32'hFFFFFFEB; data_exception=0; busy high over E0..E32.
- MULT 32'h00010000 x 32'h00010000 -> data_result=0, data_exception=1. Then MULT 32'h0000FFFF x 2 -> 32'h0001FFFE, exception 0.
- DIV -100 / 7 -> 32'hFFFFFFF2 (-14), exception 0. DIV 100 / -7 -> -14. DIV 6 / 7 -> 0.
- DIV 5 / 0 -> data_result=0, data_exception=1 at the fixed latency. DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000, exception 1.
- Restart/simultaneous:
  - MULT 3 x 4 at E0, then DIV 20 / 5 at E10 -> single ready pulse 33 edges after E10, result 4; no pulse at E33 of the first op.
  - ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18.
- Reset:
  - Assert reset low asynchronously mid-edge-cycle at E15 of a DIV -> all outputs 0 immediately; no ready pulse afterwards.
  - Release reset, issue MULT 2 x 2 -> 4 after normal latency.
